sd_note_arbiter: RTL and testbench
==================================

# sd_note_arbiter

Sequencer and arbiter in front of the single SD sample-streaming path (`SDFeed`). It accepts note-on/note-off requests from `NREQ` requesters (MIDI decoder, test sequencer, etc.) and grants them round-robin. It turns each grant into correctly ordered single-cycle `note_on`/`note_off` pulses with a sample `id`, and tracks the active note. A note-on that arrives while a note is playing first stops the current note and waits for `completed`. Only then does it start the new one.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TO_CYCLES`, 1_000_000: watchdog limit in `clk96m` cycles while waiting for `completed`. Present only with `SDARB_TIMEOUT_EN`.

Ports:
- `clk96m` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_on` in NREQ: 1 = note-on, 0 = note-off.
- `req_id` in 8*NREQ: sample code; requester i uses bits [8i+7:8i].
- `req_ack` out NREQ: one-cycle, one-hot acceptance pulse.
- `sd_id` out 8: sample code to `SDFeed`, held stable from the issue pulse until the next issue.
- `sd_note_on` out 1: one-cycle start pulse.
- `sd_note_off` out 1: one-cycle stop pulse.
- `sd_completed` in 1: `SDFeed` reports that the stream has ended or stopped.
- `playing` out 1: a note is active.
- `active_id` out 8: id of the active note.
- `busy` out 1: arbiter not accepting requests.
- `timeout_err` out 1: sticky watchdog flag. Tied 0 when the macro is absent.

## Operation
- States: `IDLE`, `ISSUE_ON`, `PLAY`, `ISSUE_OFF`, `WAIT_OFF`.
- Acceptance happens only in `IDLE` and `PLAY`. The winner is the first asserted `req_valid` found searching upward from `rr_ptr` and wrapping. After a grant to requester k, `rr_ptr` = (k+1) mod NREQ.
- On accept, latch the winner's `req_on` and `req_id` into `pend_on`/`pend_id`, then:
  - IDLE, on → `ISSUE_ON`.
  - IDLE, off → drop: ack only, stay `IDLE`.
  - PLAY, on → `ISSUE_OFF` with `pend_restart=1`.
  - PLAY, off, `pend_id==active_id` → `ISSUE_OFF` with `pend_restart=0`.
  - PLAY, off, other id → drop: ack only, stay `PLAY`.
- `ISSUE_ON`: pulse `sd_note_on`, set `sd_id`/`active_id` = `pend_id`, set `playing`=1, go to `PLAY`.
- `PLAY`: if `sd_completed`=1 (the sample ended naturally), clear `playing` and go to `IDLE`. `sd_completed` takes priority over a same-cycle request, so the request is not accepted that cycle.
- `ISSUE_OFF`: pulse `sd_note_off` (`sd_id` unchanged), go to `WAIT_OFF`.
- `WAIT_OFF`: on `sd_completed`, clear `playing`. Then go to `ISSUE_ON` if `pend_restart`, otherwise to `IDLE`.
- `busy` = state ∉ {`IDLE`, `PLAY`}.
- `sd_completed` is ignored in `IDLE`, `ISSUE_ON` and `ISSUE_OFF`.

## Timing
- Reset values: state `IDLE`, `rr_ptr`=0, all outputs 0 (`sd_id`=0, `active_id`=0, `timeout_err`=0).
- If `req_valid[k]` wins in cycle T, `req_ack[k]`=1 in T+1 only. The requester must deassert `req_valid` or present a new request by T+2. `req_valid` is ignored during T+1 in every case.
- Note-on from `IDLE`: request at T, `sd_note_on` at T+1, `playing`=1 from T+2.
- Preempting note-on: `sd_note_off` at T+1. If `sd_completed` arrives at cycle C, `sd_note_on` with the new id is at C+1, and `playing` stays 0 only during C+1.
- Registered outputs only; no combinational path from input to output.
- Reset mid-operation returns to `IDLE` next cycle with no pulse emitted. `SDFeed` shares `rst`.

## Configuration
- `SDARB_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_OFF` and clears on entry to that state.
  - When it reaches `TO_CYCLES-1` without `sd_completed`, the block sets `timeout_err` (sticky until `rst`), clears `playing`, and takes the same next state as on `sd_completed`.
- Not defined: no counter; `WAIT_OFF` waits indefinitely; `timeout_err` is constant 0.

## Test plan
- Reset, then `req_valid`=0001, on, id 0x12 → `req_ack`=0001 at T+1, `sd_note_on` with `sd_id`=0x12 at T+1, `playing`=1, `active_id`=0x12.
- Playing 0x12; requester 2 sends on, id 0x30 → `sd_note_off` (id 0x12) at T+1. Drive `sd_completed` 5 cycles later → `sd_note_on` with id 0x30 next cycle.
- All four requesters valid continuously, each with a note-off for a non-active id → acks cycle 0001, 0010, 0100, 1000, 0001, no sd pulses.
- Playing 0x12; note-off for 0x13 dropped with no pulse. Note-off for 0x12 → `sd_note_off`, then after `sd_completed`: `playing`=0, state `IDLE`.
- `sd_completed` in `PLAY` in the same cycle as `req_valid` → `playing` clears, no ack that cycle, ack follows 1 cycle later.
- With `SDARB_TIMEOUT_EN` and `TO_CYCLES`=16: `sd_note_off`, no `sd_completed` → `timeout_err`=1 16 cycles after entering `WAIT_OFF`, `playing`=0. `rst` mid-`WAIT_OFF` → all outputs 0 next cycle.

Source files
------------

// File: rtl/sd_note_arbiter_if.sv
// Request / SDFeed bundle for sd_note_arbiter.
// master: requesters and SDFeed side. slave: the arbiter.
interface sd_note_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_on;
   logic [8*NREQ-1:0] req_id;
   logic [NREQ-1:0]   req_ack;
   logic [7:0]        sd_id;
   logic              sd_note_on;
   logic              sd_note_off;
   logic              sd_completed;
   logic              playing;
   logic [7:0]        active_id;
   logic              busy;
   logic              timeout_err;

   modport master (
      output req_valid, req_on, req_id, sd_completed,
      input  req_ack, sd_id, sd_note_on, sd_note_off, playing, active_id, busy, timeout_err
   );

   modport slave (
      input  req_valid, req_on, req_id, sd_completed,
      output req_ack, sd_id, sd_note_on, sd_note_off, playing, active_id, busy, timeout_err
   );
endinterface

// File: rtl/sd_note_arbiter.sv
// Round-robin note arbiter and sequencer in front of SDFeed.
// Optional macro SDARB_TIMEOUT_EN adds a WAIT_OFF watchdog (TO_CYCLES) and a
// sticky timeout_err; without it timeout_err is tied 0.
module sd_note_arbiter #(
   parameter int unsigned NREQ      = 4
`ifdef SDARB_TIMEOUT_EN
   ,parameter int unsigned TO_CYCLES = 1_000_000
`endif
) (
   input  logic               clk96m,
   input  logic               rst,
   sd_note_arbiter_if.slave   bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE_ON  = 3'd1,
      S_PLAY      = 3'd2,
      S_ISSUE_OFF = 3'd3,
      S_WAIT_OFF  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [7:0]        sd_id_q, sd_id_d;
   logic [7:0]        active_id_q, active_id_d;
   logic [7:0]        pend_id_q, pend_id_d;
   logic              pend_restart_q, pend_restart_d;
   logic              note_on_q, note_on_d;
   logic              note_off_q, note_off_d;
   logic              playing_q, playing_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;

   logic              found_c;
   logic [PW-1:0]     win_c;
   logic              win_on_c;
   logic [7:0]        win_id_c;
   logic              accept_c;
   logic              to_fire_c;

   // Round-robin search upward from rr_ptr, wrapping.
   always_comb begin
      found_c = 1'b0;
      win_c   = '0;
      for (int unsigned o = 0; o < NREQ; o++) begin
         int unsigned idx;
         idx = (32'(rr_ptr_q) + o) % NREQ;
         if (!found_c && bus.req_valid[idx]) begin
            found_c = 1'b1;
            win_c   = PW'(idx);
         end
      end
   end

   assign win_on_c = bus.req_on[win_c];
   assign win_id_c = bus.req_id[{win_c, 3'b000} +: 8];
   // ack_q nonzero marks the cycle after a grant, in which requests are ignored
   assign accept_c = found_c && (ack_q == '0) &&
                     ((state_q == S_IDLE) || ((state_q == S_PLAY) && !bus.sd_completed));

`ifdef SDARB_TIMEOUT_EN
   localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   logic [CW-1:0] to_cnt_q;

   // Watchdog counter: zero on entry to WAIT_OFF, counts while there.
   always_ff @(posedge clk96m) begin
      if (rst || (state_q != S_WAIT_OFF)) to_cnt_q <= '0;
      else                                to_cnt_q <= to_cnt_q + 1'b1;
   end

   assign to_fire_c = (state_q == S_WAIT_OFF) && !bus.sd_completed &&
                      (to_cnt_q == CW'(TO_CYCLES - 1));
`else
   assign to_fire_c = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk96m) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept_c && win_on_c) state_d = S_ISSUE_ON;
         S_ISSUE_ON:  state_d = S_PLAY;
         S_PLAY: begin
            if (bus.sd_completed) state_d = S_IDLE;
            else if (accept_c && (win_on_c || (win_id_c == active_id_q))) state_d = S_ISSUE_OFF;
         end
         S_ISSUE_OFF: state_d = S_WAIT_OFF;
         S_WAIT_OFF:  if (bus.sd_completed || to_fire_c)
                         state_d = pend_restart_q ? S_ISSUE_ON : S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values, decoded from the next state so pulses are registered.
   always_comb begin
      ack_d          = '0;
      note_on_d      = 1'b0;
      note_off_d     = 1'b0;
      sd_id_d        = sd_id_q;
      active_id_d    = active_id_q;
      pend_id_d      = pend_id_q;
      pend_restart_d = pend_restart_q;
      rr_ptr_d       = rr_ptr_q;
      playing_d      = playing_q;
      busy_d         = !((state_d == S_IDLE) || (state_d == S_PLAY));
      timeout_d      = timeout_q | to_fire_c;

      if (accept_c) begin
         ack_d          = NREQ'(1) << win_c;
         pend_id_d      = win_id_c;
         pend_restart_d = (state_q == S_PLAY) && win_on_c;
         rr_ptr_d       = (32'(win_c) == NREQ - 1) ? '0 : PW'(win_c + 1'b1);
      end

      if (state_d == S_ISSUE_ON) begin
         note_on_d   = 1'b1;
         sd_id_d     = pend_id_d;
         active_id_d = pend_id_d;
      end
      if (state_d == S_ISSUE_OFF) note_off_d = 1'b1;

      case (state_q)
         S_ISSUE_ON: playing_d = 1'b1;
         S_PLAY:     if (bus.sd_completed) playing_d = 1'b0;
         S_WAIT_OFF: if (bus.sd_completed || to_fire_c) playing_d = 1'b0;
         default:    ;
      endcase
   end

   // Registered outputs and datapath.
   always_ff @(posedge clk96m) begin
      if (rst) begin
         ack_q          <= '0;
         note_on_q      <= 1'b0;
         note_off_q     <= 1'b0;
         sd_id_q        <= '0;
         active_id_q    <= '0;
         pend_id_q      <= '0;
         pend_restart_q <= 1'b0;
         rr_ptr_q       <= '0;
         playing_q      <= 1'b0;
         busy_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         ack_q          <= ack_d;
         note_on_q      <= note_on_d;
         note_off_q     <= note_off_d;
         sd_id_q        <= sd_id_d;
         active_id_q    <= active_id_d;
         pend_id_q      <= pend_id_d;
         pend_restart_q <= pend_restart_d;
         rr_ptr_q       <= rr_ptr_d;
         playing_q      <= playing_d;
         busy_q         <= busy_d;
         timeout_q      <= timeout_d;
      end
   end

   assign bus.req_ack     = ack_q;
   assign bus.sd_note_on  = note_on_q;
   assign bus.sd_note_off = note_off_q;
   assign bus.sd_id       = sd_id_q;
   assign bus.active_id   = active_id_q;
   assign bus.playing     = playing_q;
   assign bus.busy        = busy_q;
`ifdef SDARB_TIMEOUT_EN
   assign bus.timeout_err = timeout_q;
`else
   assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_sd_note_arbiter.sv
// Directed bench for sd_note_arbiter; expected values computed by hand.
// With SDARB_TIMEOUT_EN defined the watchdog is exercised with TO_CYCLES=16.
module tb_sd_note_arbiter;
   logic clk96m = 1'b0;
   logic rst    = 1'b1;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   sd_note_arbiter_if #(.NREQ(4)) bus();

`ifdef SDARB_TIMEOUT_EN
   sd_note_arbiter #(.NREQ(4), .TO_CYCLES(16)) dut (.clk96m(clk96m), .rst(rst), .bus(bus));
`else
   sd_note_arbiter #(.NREQ(4)) dut (.clk96m(clk96m), .rst(rst), .bus(bus));
`endif

   always #5 clk96m = ~clk96m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk96m);
      #1;
   endtask

   task automatic post(input int k, input logic on, input logic [7:0] id);
      bus.req_valid[k]      = 1'b1;
      bus.req_on[k]         = on;
      bus.req_id[8*k +: 8]  = id;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".ack"},     32'(bus.req_ack), 0);
      check({tag, ".on"},      32'(bus.sd_note_on), 0);
      check({tag, ".off"},     32'(bus.sd_note_off), 0);
      check({tag, ".sd_id"},   32'(bus.sd_id), 0);
      check({tag, ".active"},  32'(bus.active_id), 0);
      check({tag, ".playing"}, 32'(bus.playing), 0);
      check({tag, ".busy"},    32'(bus.busy), 0);
      check({tag, ".to"},      32'(bus.timeout_err), 0);
   endtask

   initial begin
      bus.req_valid    = '0;
      bus.req_on       = '0;
      bus.req_id       = '0;
      bus.sd_completed = 1'b0;

      // reset
      tick(); tick();
      rst = 1'b0;
      check_zero("reset");

      // note-on from IDLE, requester 0, id 0x12
      post(0, 1'b1, 8'h12);
      tick();
      check("on1.ack", 32'(bus.req_ack), 32'h1);
      check("on1.pulse", 32'(bus.sd_note_on), 1);
      check("on1.sd_id", 32'(bus.sd_id), 32'h12);
      check("on1.playing_early", 32'(bus.playing), 0);
      bus.req_valid = '0;
      tick();
      check("on1.playing", 32'(bus.playing), 1);
      check("on1.active", 32'(bus.active_id), 32'h12);
      check("on1.pulse_gone", 32'(bus.sd_note_on), 0);

      // preempting note-on from requester 2, id 0x30
      post(2, 1'b1, 8'h30);
      tick();
      check("pre.ack", 32'(bus.req_ack), 32'h4);
      check("pre.off", 32'(bus.sd_note_off), 1);
      check("pre.sd_id", 32'(bus.sd_id), 32'h12);
      bus.req_valid = '0;
      tick();
      check("pre.off_gone", 32'(bus.sd_note_off), 0);
      check("pre.busy", 32'(bus.busy), 1);
      check("pre.still_playing", 32'(bus.playing), 1);
      repeat (3) tick();
      bus.sd_completed = 1'b1;
      tick();
      bus.sd_completed = 1'b0;
      check("pre.on", 32'(bus.sd_note_on), 1);
      check("pre.new_id", 32'(bus.sd_id), 32'h30);
      check("pre.gap", 32'(bus.playing), 0);
      check("pre.active", 32'(bus.active_id), 32'h30);
      tick();
      check("pre.playing", 32'(bus.playing), 1);
      check("pre.busy_clr", 32'(bus.busy), 0);

      // four requesters with note-offs for other ids; pointer now at 3
      for (int k = 0; k < 4; k++) post(k, 1'b0, 8'(8'h40 + k));
      for (int i = 0; i < 10; i++) begin
         logic [31:0] exp_ack;
         tick();
         exp_ack = (i % 2 == 0) ? (32'h1 << ((3 + i / 2) % 4)) : 32'h0;
         check("rr.ack", 32'(bus.req_ack), exp_ack);
         check("rr.pulses", 32'(bus.sd_note_on | bus.sd_note_off), 0);
      end
      bus.req_valid = '0;
      check("rr.playing", 32'(bus.playing), 1);
      tick();

      // note-off for a non-active id is dropped (requester 0)
      post(0, 1'b0, 8'h13);
      tick();
      check("drop.ack", 32'(bus.req_ack), 32'h1);
      check("drop.off", 32'(bus.sd_note_off), 0);
      bus.req_valid = '0;
      tick();
      // note-off for the active id (requester 1)
      post(1, 1'b0, 8'h30);
      tick();
      check("off.ack", 32'(bus.req_ack), 32'h2);
      check("off.pulse", 32'(bus.sd_note_off), 1);
      check("off.sd_id", 32'(bus.sd_id), 32'h30);
      bus.req_valid = '0;
      tick();
      bus.sd_completed = 1'b1;
      tick();
      bus.sd_completed = 1'b0;
      check("off.playing", 32'(bus.playing), 0);
      check("off.idle", 32'(bus.busy), 0);
      check("off.no_on", 32'(bus.sd_note_on), 0);

      // completed in PLAY beats a same-cycle request
      post(2, 1'b1, 8'h55);
      tick();
      check("cp.ack0", 32'(bus.req_ack), 32'h4);
      bus.req_valid = '0;
      tick();
      post(3, 1'b1, 8'h66);
      bus.sd_completed = 1'b1;
      tick();
      bus.sd_completed = 1'b0;
      check("cp.playing", 32'(bus.playing), 0);
      check("cp.no_ack", 32'(bus.req_ack), 0);
      tick();
      check("cp.ack", 32'(bus.req_ack), 32'h8);
      check("cp.on", 32'(bus.sd_note_on), 1);
      check("cp.sd_id", 32'(bus.sd_id), 32'h66);
      bus.req_valid = '0;
      tick();

      // preempt and sit in WAIT_OFF
      post(0, 1'b1, 8'h77);
      tick();
      check("w.off", 32'(bus.sd_note_off), 1);
      bus.req_valid = '0;
      tick();
`ifdef SDARB_TIMEOUT_EN
      repeat (15) tick();
      check("to.not_yet", 32'(bus.timeout_err), 0);
      tick();
      check("to.flag", 32'(bus.timeout_err), 1);
      check("to.playing", 32'(bus.playing), 0);
      check("to.restart", 32'(bus.sd_note_on), 1);
      check("to.sd_id", 32'(bus.sd_id), 32'h77);
      tick();
      check("to.sticky", 32'(bus.timeout_err), 1);
      post(1, 1'b1, 8'h78);
      tick();
      bus.req_valid = '0;
      tick();
`else
      repeat (20) tick();
      check("w.busy", 32'(bus.busy), 1);
      check("w.playing", 32'(bus.playing), 1);
      check("w.to", 32'(bus.timeout_err), 0);
`endif
      // reset in WAIT_OFF
      rst = 1'b1;
      tick();
      check_zero("rst_mid");
      rst = 1'b0;
      tick();
      check("post_rst.busy", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
